// File: rtl/blob_pkg.sv
// Shared widths, FSM state type and colour-distance helper for the blob tracker.
package blob_pkg;

    localparam int unsigned WIDTH_DEF  = 320;
    localparam int unsigned HEIGHT_DEF = 240;
    localparam int unsigned CNT_W      = 17;
    localparam int unsigned SUM_W      = 25;
    localparam int unsigned X_W        = 11;
    localparam int unsigned Y_W        = 10;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } blob_state_t;

    function automatic logic [3:0] absdiff4(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock; the first bit is
// resolved on the start edge so the quotient is ready DIVIDEND_W edges later.
module seq_divider #(
    parameter int unsigned DIVIDEND_W = 25,
    parameter int unsigned DIVISOR_W  = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic                  done
);

    localparam int unsigned ITER_W = $clog2(DIVIDEND_W + 1);

    logic [DIVISOR_W-1:0]  rem;
    logic [DIVISOR_W-1:0]  dvs;
    logic [DIVISOR_W-1:0]  rem_in;
    logic [DIVISOR_W-1:0]  dvs_in;
    logic [DIVISOR_W-1:0]  rem_next;
    logic [DIVIDEND_W-1:0] quo_in;
    logic [DIVIDEND_W-1:0] quo_next;
    logic [DIVISOR_W:0]    shifted;
    logic [ITER_W-1:0]     iter;
    logic                  busy;

    // One restoring step, seeded from the operands on the start cycle.
    always_comb begin
        rem_in   = start ? '0 : rem;
        quo_in   = start ? dividend : quotient;
        dvs_in   = start ? divisor : dvs;
        shifted  = {rem_in, quo_in[DIVIDEND_W-1]};
        rem_next = shifted[DIVISOR_W-1:0];
        quo_next = {quo_in[DIVIDEND_W-2:0], 1'b0};
        if (shifted >= {1'b0, dvs_in}) begin
            rem_next    = DIVISOR_W'(shifted - {1'b0, dvs_in});
            quo_next[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem      <= '0;
            dvs      <= '0;
            quotient <= '0;
            iter     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem      <= rem_next;
                quotient <= quo_next;
                dvs      <= divisor;
                iter     <= ITER_W'(DIVIDEND_W - 1);
                busy     <= 1'b1;
            end else if (busy) begin
                rem      <= rem_next;
                quotient <= quo_next;
                iter     <= iter - ITER_W'(1);
                if (iter == ITER_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/blob_centroid.sv
// Per-frame colour blob tracker: match, accumulate coordinate sums, and divide
// at each vsync rise to publish centroid, size and found flag.
module blob_centroid
    import blob_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned HEIGHT   = HEIGHT_DEF,
    parameter int unsigned MIN_SIZE = 16
) (
    input  logic             clk_65mhz,
    input  logic             reset,
    input  logic [X_W-1:0]   hcount,
    input  logic [Y_W-1:0]   vcount,
    input  logic             vsync,
    input  logic [11:0]      pixel_in,
    input  logic [11:0]      target,
    input  logic [3:0]       tol,
    output logic [X_W-1:0]   centroid_x,
    output logic [Y_W-1:0]   centroid_y,
    output logic [CNT_W-1:0] size_out,
    output logic             found_out,
    output logic             valid_out,
    output logic             overrun_out
);

    blob_state_t      state;
    blob_state_t      state_next;
    logic             vsync_d;
    logic             edge_c;
    logic             match_c;
    logic             found_c;
    logic             snap_found_c;
    logic             start_c;
    logic             m1;
    logic [X_W-1:0]   x1;
    logic [Y_W-1:0]   y1;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] snap_count;
    logic [SUM_W-1:0] sum_x;
    logic [SUM_W-1:0] sum_y;
    logic [SUM_W-1:0] quo_x;
    logic [SUM_W-1:0] quo_y;
    logic             done_x;
    logic             done_y;
    logic             unused_c;

    assign edge_c       = vsync & ~vsync_d;
    assign found_c      = count >= CNT_W'(MIN_SIZE);
    assign snap_found_c = snap_count >= CNT_W'(MIN_SIZE);
    assign start_c      = (state == IDLE) && edge_c && found_c;
    assign unused_c     = ^{done_y, quo_x[SUM_W-1:X_W], quo_y[SUM_W-1:Y_W]};

    always_comb begin
        match_c = (hcount < X_W'(WIDTH)) && (vcount < Y_W'(HEIGHT))
               && (absdiff4(pixel_in[11:8], target[11:8]) <= tol)
               && (absdiff4(pixel_in[7:4],  target[7:4])  <= tol)
               && (absdiff4(pixel_in[3:0],  target[3:0])  <= tol);
    end

    always_ff @(posedge clk_65mhz or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (edge_c) state_next = found_c ? DIVIDE : DONE;
            DIVIDE:  if (done_x) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Match pipeline, accumulators and frame snapshot; a frame edge drops any add in flight.
    always_ff @(posedge clk_65mhz or posedge reset) begin
        if (reset) begin
            vsync_d    <= 1'b0;
            m1         <= 1'b0;
            x1         <= '0;
            y1         <= '0;
            count      <= '0;
            sum_x      <= '0;
            sum_y      <= '0;
            snap_count <= '0;
        end else begin
            vsync_d <= vsync;
            m1      <= match_c;
            x1      <= hcount;
            y1      <= vcount;
            if (edge_c) begin
                count <= '0;
                sum_x <= '0;
                sum_y <= '0;
            end else if (m1) begin
                count <= count + CNT_W'(1);
                sum_x <= sum_x + SUM_W'(x1);
                sum_y <= sum_y + SUM_W'(y1);
            end
            if ((state == IDLE) && edge_c) snap_count <= count;
        end
    end

    // Published results; centroids only move when the frame had a real blob.
    always_ff @(posedge clk_65mhz or posedge reset) begin
        if (reset) begin
            centroid_x  <= '0;
            centroid_y  <= '0;
            size_out    <= '0;
            found_out   <= 1'b0;
            valid_out   <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (state == DONE) begin
                size_out  <= snap_count;
                found_out <= snap_found_c;
                valid_out <= 1'b1;
                if (snap_found_c) begin
                    centroid_x <= X_W'(quo_x);
                    centroid_y <= Y_W'(quo_y);
                end
            end
            if (edge_c && (state != IDLE)) overrun_out <= 1'b1;
        end
    end

    seq_divider #(.DIVIDEND_W(SUM_W), .DIVISOR_W(CNT_W)) u_div_x (
        .clk      (clk_65mhz),
        .rst      (reset),
        .start    (start_c),
        .dividend (sum_x),
        .divisor  (count),
        .quotient (quo_x),
        .done     (done_x)
    );

    seq_divider #(.DIVIDEND_W(SUM_W), .DIVISOR_W(CNT_W)) u_div_y (
        .clk      (clk_65mhz),
        .rst      (reset),
        .start    (start_c),
        .dividend (sum_y),
        .divisor  (count),
        .quotient (quo_y),
        .done     (done_y)
    );

endmodule

// File: tb/tb_blob_centroid.sv
// Directed bench for blob_centroid: frame timing, centroid maths, window and
// tolerance edges, overrun and reset behaviour.
module tb_blob_centroid;

    logic        clk_65mhz = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        vsync;
    logic [11:0] pixel_in;
    logic [11:0] target;
    logic [3:0]  tol;
    logic [10:0] centroid_x;
    logic [9:0]  centroid_y;
    logic [16:0] size_out;
    logic        found_out;
    logic        valid_out;
    logic        overrun_out;

    int total = 0;
    int bad   = 0;

    blob_centroid dut (
        .clk_65mhz   (clk_65mhz),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .vsync       (vsync),
        .pixel_in    (pixel_in),
        .target      (target),
        .tol         (tol),
        .centroid_x  (centroid_x),
        .centroid_y  (centroid_y),
        .size_out    (size_out),
        .found_out   (found_out),
        .valid_out   (valid_out),
        .overrun_out (overrun_out)
    );

    always #5 clk_65mhz = ~clk_65mhz;

    task automatic tick();
        @(posedge clk_65mhz);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input int sz, input int fnd, input int cx, input int cy);
        check({tag, "_valid"}, 32'(valid_out), 32'd1);
        check({tag, "_size"},  32'(size_out),  32'(sz));
        check({tag, "_found"}, 32'(found_out), 32'(fnd));
        check({tag, "_cx"},    32'(centroid_x), 32'(cx));
        check({tag, "_cy"},    32'(centroid_y), 32'(cy));
    endtask

    task automatic drive(input int x, input int y, input logic [11:0] p);
        hcount   = 11'(x);
        vcount   = 10'(y);
        pixel_in = p;
        tick();
    endtask

    task automatic blank(input int n);
        hcount   = '0;
        vcount   = '0;
        pixel_in = 12'h000;
        ticks(n);
    endtask

    task automatic send_block(input int x0, input int y0, input int w, input int h, input logic [11:0] p);
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++)
                drive(x0 + xx, y0 + yy, p);
        blank(3);
    endtask

    // Leaves the bench one step past edge 0 with vsync already dropped.
    task automatic frame_edge();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
    endtask

    initial begin
        int seen;
        reset    = 1'b1;
        vsync    = 1'b0;
        hcount   = '0;
        vcount   = '0;
        pixel_in = 12'h000;
        target   = 12'hF00;
        tol      = 4'd3;
        ticks(3);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_size",  32'(size_out),  32'd0);
        check("rst_cx",    32'(centroid_x), 32'd0);
        check("rst_ovr",   32'(overrun_out), 32'd0);
        reset = 1'b0;
        blank(2);

        // 4x4 block, found path: valid on the cycle after edge 26
        send_block(100, 50, 4, 4, 12'hF10);
        frame_edge();
        ticks(25);
        check("blk_early_valid", 32'(valid_out), 32'd0);
        tick();
        check_result("blk", 16, 1, 101, 51);
        tick();
        check("blk_pulse_len", 32'(valid_out), 32'd0);
        check("blk_hold_cx", 32'(centroid_x), 32'd101);
        blank(3);

        // Too small: not-found path, centroid holds
        send_block(10, 5, 10, 1, 12'hE23);
        frame_edge();
        tick();
        check_result("small", 10, 0, 101, 51);
        check("small_ovr", 32'(overrun_out), 32'd0);
        blank(3);

        // Outside window and one channel just past tolerance
        send_block(400, 10, 2, 1, 12'hF00);
        send_block(10, 300, 2, 1, 12'hF00);
        send_block(320, 10, 1, 1, 12'hF00);
        send_block(10, 240, 1, 1, 12'hF00);
        send_block(5, 5, 2, 1, 12'hF40);
        frame_edge();
        tick();
        check_result("outside", 0, 0, 101, 51);
        blank(3);

        // Overrun: second rise 10 cycles in; first frame still reported
        send_block(200, 100, 4, 4, 12'hF00);
        frame_edge();
        for (int i = 0; i < 5; i++) drive(20 + i, 20, 12'hF00);
        blank(4);
        check("ovr_before", 32'(overrun_out), 32'd0);
        frame_edge();
        check("ovr_set", 32'(overrun_out), 32'd1);
        ticks(15);
        check("ovr_early_valid", 32'(valid_out), 32'd0);
        tick();
        check_result("ovr", 16, 1, 201, 101);
        blank(3);
        frame_edge();
        tick();
        check_result("ovr_cleared", 0, 0, 201, 101);
        check("ovr_sticky", 32'(overrun_out), 32'd1);
        blank(3);

        // Asynchronous reset mid-frame, observed between clock edges
        for (int i = 0; i < 3; i++) drive(30 + i, 30, 12'hF00);
        #2 reset = 1'b1;
        #1;
        check("arst_cx",    32'(centroid_x), 32'd0);
        check("arst_cy",    32'(centroid_y), 32'd0);
        check("arst_ovr",   32'(overrun_out), 32'd0);
        check("arst_found", 32'(found_out), 32'd0);
        check("arst_state", 32'(dut.state), 32'd0);
        #1 reset = 1'b0;
        blank(3);

        // Reset during DIVIDE aborts the frame; the next frame is clean
        send_block(100, 50, 4, 4, 12'hF10);
        frame_edge();
        ticks(11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (valid_out === 1'b1) seen++;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        check("abort_size", 32'(size_out), 32'd0);
        send_block(50, 20, 4, 4, 12'hF00);
        frame_edge();
        ticks(25);
        check("post_early_valid", 32'(valid_out), 32'd0);
        tick();
        check_result("post", 16, 1, 51, 21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blob_centroid.md
# blob_centroid

Per-frame colour-blob tracker fed by the camera-buffer pixel stream (`cam`, 12-bit RGB444) and the XVGA raster counters. It classifies each in-window pixel against a target colour, accumulates the match count and the x/y coordinate sums across the frame, and at each vsync rising edge runs a sequential divide. The result is the blob centroid and size, which the initializer and chase logic consume.

## Interface
Parameters:
- `WIDTH`, default 320: active window width in pixels.
- `HEIGHT`, default 240: active window height in lines.
- `MIN_SIZE`, default 16: minimum match count for a valid blob. Must be ≥1.

Ports:
- `clk_65mhz`  in  1  pixel/system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `hcount`  in  11  raster x.
- `vcount`  in  10  raster y.
- `vsync`  in  1  frame sync, active-high.
- `pixel_in`  in  12  RGB444 pixel at (`hcount`, `vcount`).
- `target`  in  12  RGB444 target colour.
- `tol`  in  4  per-channel tolerance.
- `centroid_x`  out  11  floor(sum_x / count).
- `centroid_y`  out  10  floor(sum_y / count).
- `size_out`  out  17  match count of the last frame.
- `found_out`  out  1  last frame had count ≥ `MIN_SIZE`.
- `valid_out`  out  1  one-cycle pulse when outputs update.
- `overrun_out`  out  1  sticky flag; a vsync rise arrived while the divider was busy.

All outputs reset to 0.

## Operation
- **Match stage:** a pixel matches when `hcount` < `WIDTH`, `vcount` < `HEIGHT`, and for each channel |p−t| ≤ `tol`. Channel differences are unsigned 4-bit absolute differences.
- **Registering:** the match bit and `hcount`/`vcount` are registered (stage 1). Stage 2 accumulates:
  - `count` += 1 (17 bits)
  - `sum_x` += x (25 bits)
  - `sum_y` += y (25 bits)
  
  These widths cannot overflow within the window. No saturation logic is needed.
- **Edge detect:** `vsync_d` is `vsync` delayed one cycle. A frame edge is `vsync & ~vsync_d`.
- **FSM states:** IDLE, DIVIDE, DONE.
  - **IDLE, on frame edge:** snapshot `count`/`sum_x`/`sum_y`. Clear the accumulators, including any stage-2 add pending that same cycle, which is discarded. Then:
    - If snapshot count ≥ `MIN_SIZE`: start both dividers and go to DIVIDE.
    - Otherwise: go to DONE.
  - **DIVIDE:** one restoring quotient bit per cycle, 25 iterations. Go to DONE after the 25th.
  - **DONE:** update `size_out` with the snapshot count and `found_out` with (count ≥ `MIN_SIZE`).
    - If found: `centroid_x`/`centroid_y` take the truncated quotients.
    - If not found: centroids hold their previous values.
    - Pulse `valid_out`, then return to IDLE.
- **Frame edge during DIVIDE or DONE:** accumulators still clear. The snapshot is not retaken and the current divide completes with its original data. Set `overrun_out`, which clears only on reset.
- **Reset mid-operation:** asynchronous return to IDLE with accumulators and outputs at 0. No `valid_out` is produced for the aborted frame.

## Timing
- Match-to-accumulate latency is 2 cycles.
- Call the clock edge that samples the frame edge "edge 0".
  - **Found path:** DIVIDE occupies edges 1–25, DONE is edge 26, and `valid_out` is high for the cycle after edge 26.
  - **Not-found path:** DONE is edge 1, and `valid_out` is high for the cycle after edge 1.
- Outputs are stable from the `valid_out` cycle until the next update.
- The dividers have no handshake. The start-to-done time is fixed at 25 cycles.

## Structure
- **Package `blob_pkg`:**
  - `WIDTH`/`HEIGHT` defaults
  - `CNT_W` = 17, `SUM_W` = 25
  - state enum `blob_state_t` {IDLE, DIVIDE, DONE}
  - helper function `absdiff4`
- **Sub-module `seq_divider`:** parameterised dividend/divisor widths, with `start`, `dividend`, `divisor`, `quotient` and `done` ports. Restoring, one bit per cycle. Instantiate it twice, for x and y.

## Test plan
1. **Reset:** assert `reset` mid-frame → all outputs 0 and state IDLE, immediately and without a clock edge.
2. **4×4 block:** `target` = F00, `tol` = 3, block of F10 at x 100–103, y 50–53, rest 000. Raise vsync → `valid_out` pulses 26 cycles after the edge, with `size_out` = 16, `centroid` = (101, 51), `found_out` = 1.
3. **Too small:** 10 matching pixels → `valid_out` 1 cycle after the edge, `size_out` = 10, `found_out` = 0, centroid holds the previous (101, 51).
4. **Outside window:** matching pixels at `hcount` = 400 or `vcount` = 300 only → `size_out` = 0, `found_out` = 0.
5. **Overrun:** second vsync rise 10 cycles after the first found edge → `overrun_out` = 1. `valid_out` still at cycle 26 with the first frame's result, and the accumulators are cleared.
6. **Reset during DIVIDE:** at cycle 12 → no `valid_out`. The next full frame produces correct results.
